// File: rtl/y_sram_rr_arbiter.sv
// y_sram_rr_arbiter
// Round-robin arbiter for one dual-read/single-write Y SRAM port set shared by
// NUM_CH requesters. A grant is held until the owner pulses done or the
// watchdog expires, followed by one turnaround cycle with no grant.
//
// Ports:
//   clock             sole clock, rising edge
//   reset             synchronous active-low reset
//   in_req            per-channel level request
//   in_done           per-channel release pulse (only the owner's counts)
//   in_rdAddr1/2      per-channel read addresses, channel k at [k*ADDR_W +: ADDR_W]
//   in_we             per-channel write enable
//   in_wrAddr         per-channel write address
//   in_wrData         per-channel write data, channel k at [k*DATA_W +: DATA_W]
//   op_grant          registered one-hot grant
//   op_yReadAddress1/2, op_yWriteEnable, op_yWriteAddress, op_writeData
//                     SRAM port, routed from the granted channel
//   op_busy           high while a channel owns the bus
//   op_timeoutErr     one-cycle pulse on a watchdog release
//   op_errCh          channel of the last watchdog release, sticky until reset
module y_sram_rr_arbiter #(
    parameter int unsigned       NUM_CH    = 4,
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       DATA_W    = 256,
    parameter int unsigned       TIMEOUT   = 1023,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_req,
    input  logic [NUM_CH-1:0]        in_done,
    input  logic [NUM_CH*ADDR_W-1:0] in_rdAddr1,
    input  logic [NUM_CH*ADDR_W-1:0] in_rdAddr2,
    input  logic [NUM_CH-1:0]        in_we,
    input  logic [NUM_CH*ADDR_W-1:0] in_wrAddr,
    input  logic [NUM_CH*DATA_W-1:0] in_wrData,
    output logic [NUM_CH-1:0]        op_grant,
    output logic [ADDR_W-1:0]        op_yReadAddress1,
    output logic [ADDR_W-1:0]        op_yReadAddress2,
    output logic                     op_yWriteEnable,
    output logic [ADDR_W-1:0]        op_yWriteAddress,
    output logic [DATA_W-1:0]        op_writeData,
    output logic                     op_busy,
    output logic                     op_timeoutErr,
    output logic [2:0]               op_errCh
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned    CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [2:0]        err_ch_q, err_ch_d;

    logic              any_req;
    logic [2:0]        sel;
    logic [NUM_CH-1:0] sel_onehot;
    logic [2:0]        g_idx;
    logic              owner_done;

    // Rotating priority: first requester at or after ptr+1, wrapping.
    always_comb begin
        int unsigned idx;
        any_req    = 1'b0;
        sel        = '0;
        sel_onehot = '0;
        idx        = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (!any_req && in_req[idx]) begin
                any_req         = 1'b1;
                sel             = 3'(idx);
                sel_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        g_idx = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant_q[k]) g_idx = 3'(k);
        end
    end

    // Done from a non-owner is masked off here.
    assign owner_done = |(in_done & grant_q);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            ptr_q    <= 3'(NUM_CH - 1);
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        err_ch_d = err_ch_q;
        unique case (state_q)
            // RELEASE arbitrates with the already-updated pointer, so a
            // pending request is granted straight away without visiting IDLE.
            StIdle, StRelease: begin
                if (any_req) begin
                    state_d = StGrant;
                    grant_d = sel_onehot;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            StGrant: begin
                if (owner_done) begin
                    // Done wins over a simultaneous watchdog expiry.
                    state_d = StRelease;
                    grant_d = '0;
                    ptr_d   = g_idx;
                end else if (TIMEOUT != 0 && cnt_q == CntMax) begin
                    state_d  = StRelease;
                    grant_d  = '0;
                    ptr_d    = g_idx;
                    err_d    = 1'b1;
                    err_ch_d = g_idx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: AND-OR mux on the registered one-hot grant.
    always_comb begin
        op_grant         = grant_q;
        op_busy          = (state_q == StGrant);
        op_timeoutErr    = err_q;
        op_errCh         = err_ch_q;
        op_yReadAddress1 = IDLE_ADDR;
        op_yReadAddress2 = IDLE_ADDR;
        op_yWriteAddress = IDLE_ADDR;
        op_yWriteEnable  = 1'b0;
        op_writeData     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant_q[k]) begin
                op_yReadAddress1 = in_rdAddr1[k*ADDR_W +: ADDR_W];
                op_yReadAddress2 = in_rdAddr2[k*ADDR_W +: ADDR_W];
                op_yWriteAddress = in_wrAddr[k*ADDR_W +: ADDR_W];
                op_yWriteEnable  = in_we[k];
                op_writeData     = in_wrData[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: doc/y_sram_rr_arbiter.md
Name: y_sram_rr_arbiter

Overview:
- Parametrised successor to the two-way Y-SRAM round-robin/bus-arbitration pair.
- Arbitrates NUM_CH requesters (Y-update compute, Y-write-back, and future solver paths) for one dual-read/single-write Y SRAM port set.
- Grant is held until the owner signals done, or until a watchdog expires.
- Routes the granted channel's read addresses, write enable, write address and write data to the SRAM.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- ADDR_W, 11, Y SRAM row address width
- DATA_W, 256, Y SRAM row data width
- TIMEOUT, 1023, maximum grant cycles without done; 0 disables the watchdog
- IDLE_ADDR, all-ones (11'h7ff), read/write address driven when no channel is granted

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- in_req  in  NUM_CH  per-channel bus request, level
- in_done  in  NUM_CH  per-channel release, 1-cycle pulse from the owner
- in_rdAddr1  in  NUM_CH*ADDR_W  per-channel read address 1, channel k at bits [k*ADDR_W +: ADDR_W]
- in_rdAddr2  in  NUM_CH*ADDR_W  per-channel read address 2
- in_we  in  NUM_CH  per-channel write enable
- in_wrAddr  in  NUM_CH*ADDR_W  per-channel write address
- in_wrData  in  NUM_CH*DATA_W  per-channel write data
- op_grant  out  NUM_CH  one-hot grant, registered
- op_yReadAddress1  out  ADDR_W  to SRAM ReadAddress1
- op_yReadAddress2  out  ADDR_W  to SRAM ReadAddress2
- op_yWriteEnable  out  1  to SRAM WE
- op_yWriteAddress  out  ADDR_W  to SRAM WriteAddress
- op_writeData  out  DATA_W  to SRAM WriteBus
- op_busy  out  1  high in GRANT
- op_timeoutErr  out  1  1-cycle pulse on watchdog release
- op_errCh  out  3  channel index of last watchdog release, sticky until reset

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; op_grant=0; op_busy=0; op_timeoutErr=0; op_errCh=0; rr pointer=NUM_CH-1 (channel 0 wins first); watchdog counter=0. Takes effect mid-grant: grant drops at that edge, with no done and no error.
- States: IDLE, GRANT, RELEASE.
- IDLE: if any in_req, select the first requesting channel scanning from (ptr+1) mod NUM_CH upward with wrap. The next edge loads op_grant (one-hot) and enters GRANT. Latency from req sampled high to grant visible is 1 cycle.
- GRANT: the muxes route channel g. op_yWriteEnable = in_we[g]. Read addresses, write address and write data come from slice g. Route is combinational from the registered grant.
- GRANT: dropping in_req[g] does not release the bus; only in_done[g] releases it. in_done on a non-granted channel is ignored.
- in_done[g] at an edge: ptr=g, op_grant=0, go to RELEASE.
- RELEASE is one turnaround cycle with no grant. During RELEASE the arbiter evaluates in_req using the updated ptr. If any request is pending, the next edge grants directly (skips IDLE); otherwise it goes to IDLE. Back-to-back handover gap is exactly 1 idle bus cycle.
- Watchdog (TIMEOUT>0): the counter clears on entry to GRANT and increments each GRANT cycle.
- Watchdog expiry: when the counter==TIMEOUT-1 and in_done[g]==0, the next edge force-releases: ptr=g, op_errCh=g, op_timeoutErr=1 for that cycle, go to RELEASE.
- Watchdog vs done: done and expiry in the same cycle count as a normal done, with no error.
- Ungranted outputs (IDLE/RELEASE/reset): both read addresses and the write address = IDLE_ADDR; op_yWriteEnable=0; op_writeData=0.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 grants.

Test Plan:
- Single request: in_req=4'b0100, done after 5 cycles -> op_grant=4'b0100 one cycle after req; op_yReadAddress1 = ch2 slice; release, then 1-cycle gap, then IDLE_ADDR=0x7ff and WE=0.
- All four requesting constantly, each doing done after 3 grant cycles -> grant order 0,1,2,3,0. Exactly 1 no-grant cycle between grants.
- Write routing: ch1 granted, in_we[1]=1, addr=0x010, data=256'hA5… -> SRAM WE=1, WriteAddress=0x010, WriteBus=A5…. in_we[3]=1 while ch1 is granted -> no effect.
- Watchdog: TIMEOUT=8, ch3 granted and never done -> grant drops after 8 grant cycles; op_timeoutErr pulses once; op_errCh=3; ch0 granted next if requesting.
- Done and expiry coincide on cycle 8 -> normal release, op_timeoutErr stays 0.
- Reset (reset=0 for 1 cycle) mid-grant -> all outputs return to reset values next edge; the next grant goes to channel 0.
